// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared I2S constants, sample type and LRCK polarity (I2S_TX_LJ_EN selects left-justified)
package i2s_pkg;
    localparam int I2S_FRAME = 24;
    localparam int I2S_SLOT  = 32;

    typedef logic signed [I2S_FRAME-1:0] sample_t;

`ifdef I2S_TX_LJ_EN
    localparam logic LRCK_LEFT  = 1'b1;
    localparam logic LRCK_RIGHT = 1'b0;
    // slot position carrying the sample MSB
    localparam int   DATA_OFS   = 0;
`else
    localparam logic LRCK_LEFT  = 1'b0;
    localparam logic LRCK_RIGHT = 1'b1;
    localparam int   DATA_OFS   = 1;
`endif
endpackage

// File: rtl/i2s_tx_if.sv
// rtl/i2s_tx_if.sv - sample-pair valid/ready handshake into the I2S transmitter
interface i2s_tx_if #(
    parameter int FRAME = i2s_pkg::I2S_FRAME
);
    logic signed [FRAME-1:0] l_data;
    logic signed [FRAME-1:0] r_data;
    logic                    valid;
    logic                    ready;

    modport master (output l_data, output r_data, output valid, input ready);
    modport slave  (input l_data, input r_data, input valid, output ready);
endinterface

// File: rtl/i2s_tx_clkgen.sv
// rtl/i2s_tx_clkgen.sv - BCK/LRCK divider with bit tick and frame-start strobes (I2S_TX_LJ_EN flips LRCK)
module i2s_tx_clkgen
    import i2s_pkg::*;
#(
    parameter int SLOT    = I2S_SLOT,
    parameter int MCK_DIV = 4
) (
    input  logic                    mck_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    output logic                    bck_o,
    output logic                    lrck_o,
    output logic                    tick,
    output logic                    frame_start,
    output logic [$clog2(SLOT)-1:0] next_pos,
    output logic                    next_chan
);
    localparam int DW = $clog2(MCK_DIV);
    localparam int PW = $clog2(SLOT);
    localparam logic [DW-1:0] DIV_HALF = DW'(MCK_DIV / 2 - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(MCK_DIV - 1);
    localparam logic [PW-1:0] POS_LAST = PW'(SLOT - 1);

    logic [DW-1:0] div_cnt;
    logic [PW-1:0] pos;
    logic          chan;

    // next_pos/next_chan describe the bit position entered on this tick
    always_comb begin
        next_pos  = (pos == POS_LAST) ? '0 : pos + PW'(1);
        next_chan = (pos == POS_LAST) ? ~chan : chan;
    end

    assign tick        = enable_i && (div_cnt == DIV_LAST);
    assign frame_start = tick && (pos == POS_LAST) && chan;

    always_ff @(posedge mck_i or posedge rst_i) begin
        if (rst_i) begin
            div_cnt <= '0;
            pos     <= '0;
            chan    <= 1'b0;
            bck_o   <= 1'b0;
            lrck_o  <= 1'b0;
        end else if (!enable_i) begin
            div_cnt <= '0;
            pos     <= '0;
            chan    <= 1'b0;
            bck_o   <= 1'b0;
            lrck_o  <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DW'(1);
            if (div_cnt == DIV_HALF) begin
                bck_o <= 1'b1;
            end
            if (tick) begin
                bck_o <= 1'b0;
                pos   <= next_pos;
                chan  <= next_chan;
                if (next_pos == '0) begin
                    lrck_o <= next_chan ? LRCK_RIGHT : LRCK_LEFT;
                end
            end
        end
    end
endmodule

// File: rtl/i2s_tx.sv
// rtl/i2s_tx.sv - I2S master transmitter: holding register, shift registers, serial data and underrun
// Build option I2S_TX_LJ_EN selects left-justified framing instead of standard I2S.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int FRAME   = I2S_FRAME,
    parameter int SLOT    = I2S_SLOT,
    parameter int MCK_DIV = 4
) (
    input  logic    mck_i,
    input  logic    rst_i,
    input  logic    enable_i,
    i2s_tx_if.slave smp,
    output logic    bck_o,
    output logic    lrck_o,
    output logic    sdata_o,
    output logic    underrun_o
);
    localparam int PW = $clog2(SLOT);
    localparam logic [PW-1:0] P_LAST = PW'(DATA_OFS + FRAME - 1);

    logic             tick;
    logic             frame_start;
    logic             next_chan;
    logic [PW-1:0]    next_pos;
    logic             hold_full;
    logic             first_frame;
    logic             in_data;
    logic [FRAME-1:0] hold_l, hold_r;
    logic [FRAME-1:0] l_sr, r_sr;
    logic [FRAME-1:0] load_l, load_r;
    logic [FRAME-1:0] cur_l, cur_r;

    i2s_tx_clkgen #(
        .SLOT    (SLOT),
        .MCK_DIV (MCK_DIV)
    ) u_clkgen (
        .mck_i       (mck_i),
        .rst_i       (rst_i),
        .enable_i    (enable_i),
        .bck_o       (bck_o),
        .lrck_o      (lrck_o),
        .tick        (tick),
        .frame_start (frame_start),
        .next_pos    (next_pos),
        .next_chan   (next_chan)
    );

    assign smp.ready = !hold_full;

    // On the load tick the shifters see the incoming frame, so left-justified MSB goes out at once
    always_comb begin
        load_l = hold_full ? hold_l : '0;
        load_r = hold_full ? hold_r : '0;
        cur_l  = frame_start ? load_l : l_sr;
        cur_r  = frame_start ? load_r : r_sr;
`ifdef I2S_TX_LJ_EN
        in_data = (next_pos <= P_LAST);
`else
        in_data = (next_pos != '0) && (next_pos <= P_LAST);
`endif
    end

    always_ff @(posedge mck_i or posedge rst_i) begin
        if (rst_i) begin
            hold_l      <= '0;
            hold_r      <= '0;
            hold_full   <= 1'b0;
            l_sr        <= '0;
            r_sr        <= '0;
            sdata_o     <= 1'b0;
            underrun_o  <= 1'b0;
            first_frame <= 1'b1;
        end else begin
            underrun_o <= 1'b0;
            if (frame_start && hold_full) begin
                hold_full <= 1'b0;
            end else if (smp.valid && !hold_full) begin
                hold_l    <= smp.l_data;
                hold_r    <= smp.r_data;
                hold_full <= 1'b1;
            end

            if (!enable_i) begin
                l_sr        <= '0;
                r_sr        <= '0;
                sdata_o     <= 1'b0;
                first_frame <= 1'b1;
            end else if (tick) begin
                if (frame_start) begin
                    l_sr        <= load_l;
                    r_sr        <= load_r;
                    first_frame <= 1'b0;
                    underrun_o  <= !hold_full && !first_frame;
                end
                if (!in_data) begin
                    sdata_o <= 1'b0;
                end else if (next_chan) begin
                    sdata_o <= cur_r[FRAME-1];
                    r_sr    <= cur_r << 1;
                end else begin
                    sdata_o <= cur_l[FRAME-1];
                    l_sr    <= cur_l << 1;
                end
            end
        end
    end
endmodule
